// File: rtl/nor_gate_arbiter.sv
// Round-robin arbiter that time-shares one W-bit NOR array among N requesters.
// Operands are registered toward the array at grant; the result is captured one edge later.
//
// state | meaning
// IDLE  | waiting for any req; picks a winner and launches operands
// EVAL  | shared array settling; capture nor_y and pulse rsp_valid
module nor_gate_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_y,
  output logic [W-1:0]   nor_a,
  output logic [W-1:0]   nor_b,
  input  logic [W-1:0]   nor_y,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] last_gnt_q, last_gnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_y_q, rsp_y_d;
  logic [W-1:0]  nor_a_q, nor_a_d;
  logic [W-1:0]  nor_b_q, nor_b_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic [W-1:0]  sel_a, sel_b;

  // First pass covers indices above the last winner, second pass wraps to the bottom.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[i] && (IW'(i) > last_gnt_q)) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
        win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        sel_a = a_in[i*W +: W];
        sel_b = b_in[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= IW'(N - 1);
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      nor_a_q     <= '0;
      nor_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      nor_a_q     <= nor_a_d;
      nor_b_q     <= nor_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = EVAL;
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // gnt_q still holds the winner's one-hot during EVAL, so it doubles as the response target.
  always_comb begin
    last_gnt_d  = last_gnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_y_d     = rsp_y_q;
    nor_a_d     = nor_a_q;
    nor_b_d     = nor_b_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d      = win_oh;
          last_gnt_d = win_idx;
          nor_a_d    = sel_a;
          nor_b_d    = sel_b;
        end
      end
      EVAL: begin
        rsp_y_d     = nor_y;
        rsp_valid_d = gnt_q;
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign nor_a     = nor_a_q;
  assign nor_b     = nor_b_q;
  assign busy      = (state_q == EVAL);

endmodule

// File: tb/tb_nor_gate_arbiter.sv
// Bench for nor_gate_arbiter: tasks queue expected grants, a negedge monitor
// checks grants and responses against the queues.
module tb_nor_gate_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   gnt, rsp_valid;
  logic [W-1:0]   rsp_y, nor_a, nor_b, nor_y;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {int idx; logic [W-1:0] a; logic [W-1:0] b;} gnt_exp_t;
  typedef struct {int idx; logic [W-1:0] y;} rsp_exp_t;
  gnt_exp_t gq[$];
  rsp_exp_t rq[$];
  logic [N-1:0] prev_gnt = '0;

  nor_gate_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .nor_a(nor_a), .nor_b(nor_b), .nor_y(nor_y), .busy(busy)
  );

  assign nor_y = ~(nor_a | nor_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: grant/response scoreboard plus timing relationships.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      checks++;
      if ((gnt !== '0) && (rsp_valid !== '0)) begin
        errors++;
        $display("FAIL overlap: gnt=%b rsp_valid=%b required one of them zero", gnt, rsp_valid);
      end
      checks++;
      if (busy !== (gnt !== '0)) begin
        errors++;
        $display("FAIL busy: busy=%b gnt=%b required busy only in grant cycle", busy, gnt);
      end
      if (prev_gnt !== '0) begin
        checks++;
        if (rsp_valid !== prev_gnt) begin
          errors++;
          $display("FAIL rsp_timing: rsp_valid=%b required %b", rsp_valid, prev_gnt);
        end
      end
      if (gnt !== '0) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_gnt: gnt=%b required none", gnt);
        end else begin
          gnt_exp_t e;
          logic [N-1:0] oh;
          e = gq.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          if (gnt !== oh || nor_a !== e.a || nor_b !== e.b) begin
            errors++;
            $display("FAIL grant: gnt=%b nor_a=%h nor_b=%h required gnt=%b nor_a=%h nor_b=%h",
                     gnt, nor_a, nor_b, oh, e.a, e.b);
          end
          rq.push_back('{idx: e.idx, y: ~(e.a | e.b)});
        end
      end
      if (rsp_valid !== '0) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=%b rsp_y=%h required none", rsp_valid, rsp_y);
        end else begin
          rsp_exp_t r;
          logic [N-1:0] oh;
          r = rq.pop_front();
          oh = '0;
          oh[r.idx] = 1'b1;
          if (rsp_valid !== oh || rsp_y !== r.y) begin
            errors++;
            $display("FAIL response: rsp_valid=%b rsp_y=%h required rsp_valid=%b rsp_y=%h",
                     rsp_valid, rsp_y, oh, r.y);
          end
        end
      end
      prev_gnt = gnt;
    end
  end

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic push_gnt(input int i);
    gq.push_back('{idx: i, a: a_in[i*W +: W], b: b_in[i*W +: W]});
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (gnt !== '0) ok = 1'b1;
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (gq.size() == 0 && rq.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== '0 || rsp_valid !== '0 || rsp_y !== '0 || nor_a !== '0 || nor_b !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: gnt=%b rsp_valid=%b rsp_y=%h nor_a=%h nor_b=%h busy=%b required all zero",
               gnt, rsp_valid, rsp_y, nor_a, nor_b, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: gnt=%b busy=%b required 0", gnt, busy);
    end
  endtask

  task automatic test_single;
    bit ok;
    set_ops(0, 8'h0F, 8'h30);
    req = 4'b0001;
    push_gnt(0);
    wait_gnt(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_gnt_timeout: no gnt required gnt=0001"); end
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain: pending=%0d required 0", gq.size() + rq.size()); end
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_y !== 8'hC0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: rsp_y=%h busy=%b required C0 0", rsp_y, busy);
    end
  endtask

  task automatic test_all_from_reset;
    bit ok;
    int cnt, last_c;
    @(negedge clk);
    rst_n = 1'b0;
    gq.delete();
    rq.delete();
    for (int i = 0; i < N; i++) set_ops(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    req = '1;
    push_gnt(0); push_gnt(1); push_gnt(2); push_gnt(3); push_gnt(0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    last_c = 0;
    for (int c = 0; c < 30 && cnt < 5; c++) begin
      @(negedge clk);
      if (gnt !== '0) begin
        cnt++;
        if (cnt > 1) begin
          checks++;
          if (cyc - last_c != 2) begin
            errors++;
            $display("FAIL gnt_spacing: gap=%0d required 2", cyc - last_c);
          end
        end
        last_c = cyc;
      end
    end
    req = '0;
    checks++;
    if (cnt != 5) begin errors++; $display("FAIL all_gnt_count: got=%0d required 5", cnt); end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL all_drain: pending=%0d required 0", gq.size() + rq.size()); end
  endtask

  task automatic test_fairness;
    bit ok;
    set_ops(2, 8'h12, 8'h40);
    set_ops(0, 8'h81, 8'h18);
    req = 4'b0100;
    push_gnt(2);
    wait_gnt(ok);
    req = 4'b0101;
    push_gnt(0);
    push_gnt(2);
    wait_gnt(ok);
    checks++;
    if (!ok || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL fair_first: gnt=%b required 0001", gnt);
    end
    req = 4'b0100;
    wait_gnt(ok);
    checks++;
    if (!ok || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL fair_second: gnt=%b required 0100", gnt);
    end
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fair_drain: pending=%0d required 0", gq.size() + rq.size()); end
  endtask

  task automatic test_corners;
    bit ok;
    logic [W-1:0] ca [4] = '{8'h00, 8'hFF, 8'hAA, 8'hA0};
    logic [W-1:0] cb [4] = '{8'h00, 8'h00, 8'h55, 8'h05};
    logic [W-1:0] cy [4] = '{8'hFF, 8'h00, 8'h00, 8'h5A};
    for (int k = 0; k < 4; k++) begin
      set_ops(k, ca[k], cb[k]);
      req = '0;
      req[k] = 1'b1;
      push_gnt(k);
      wait_gnt(ok);
      req = '0;
      wait_drain(ok);
      checks++;
      if (!ok || rsp_y !== cy[k]) begin
        errors++;
        $display("FAIL corner%0d: rsp_y=%h required %h", k, rsp_y, cy[k]);
      end
    end
  endtask

  task automatic test_operand_change;
    bit ok;
    set_ops(1, 8'h00, 8'h00);
    req = 4'b0010;
    push_gnt(1);
    wait_gnt(ok);
    set_ops(1, 8'hFF, 8'h00);
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok || rsp_y !== 8'hFF) begin
      errors++;
      $display("FAIL operand_change: rsp_y=%h required FF", rsp_y);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    set_ops(2, 8'h0C, 8'h03);
    req = 4'b0100;
    push_gnt(2);
    wait_gnt(ok);
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || rsp_valid !== '0 || rsp_y !== '0 || nor_a !== '0 || nor_b !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b rsp_valid=%b rsp_y=%h nor_a=%h nor_b=%h busy=%b required all zero",
               gnt, rsp_valid, rsp_y, nor_a, nor_b, busy);
    end
    gq.delete();
    rq.delete();
    repeat (2) @(negedge clk);
    set_ops(1, 8'h33, 8'h44);
    set_ops(3, 8'h01, 8'h80);
    req = 4'b1010;
    push_gnt(1);
    push_gnt(3);
    rst_n = 1'b1;
    wait_gnt(ok);
    checks++;
    if (!ok || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_first: gnt=%b required 0010", gnt);
    end
    req = 4'b1000;
    wait_gnt(ok);
    req = '0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL post_reset_drain: pending=%0d required 0", gq.size() + rq.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_from_reset();
    test_fairness();
    test_corners();
    test_operand_change();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nor_gate_arbiter.md
# nor_gate_arbiter

Round-robin arbiter and sequencer that shares one W-bit bitwise NOR gate array among N requesters. Each requester presents an operand pair with a request. The arbiter grants one requester at a time, drives the shared gate inputs from registers, and captures the gate output. It then returns the registered result with a one-cycle valid pulse to the granted requester. It sits between the requesting logic blocks and the single shared NOR array instance.

## Interface
- N, default 4: number of requesters; must be ≥ 2.
- W, default 8: operand and result width in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous and active-low.
- req  input  N  per-requester request, level.
- a_in  input  N*W  operand A; requester i occupies bits [i*W +: W].
- b_in  input  N*W  operand B, same packing as a_in.
- gnt  output  N  one-hot grant pulse, one cycle long.
- rsp_valid  output  N  one-hot result-valid pulse, one cycle long.
- rsp_y  output  W  registered NOR result; shared by all requesters and qualified by rsp_valid.
- nor_a  output  W  registered operand A to the shared NOR array.
- nor_b  output  W  registered operand B to the shared NOR array.
- nor_y  input  W  NOR array output; purely combinational ~(nor_a | nor_b).
- busy  output  1  high while state = EVAL.

## Operation
- FSM has two states, IDLE and EVAL. Reset state is IDLE.
- IDLE with req == 0: remain in IDLE. All pulse outputs are 0.
- IDLE with req != 0:
  - Select winner w by round-robin. Search starts at index (last_gnt+1) mod N and wraps.
  - Register nor_a <= a_in[w], nor_b <= b_in[w], gnt <= onehot(w), last_gnt <= w.
  - Go to EVAL.
- EVAL:
  - Register rsp_y <= nor_y, rsp_valid <= onehot(w), gnt <= 0.
  - Return to IDLE unconditionally.
- Requester protocol:
  - Hold req, a_in and b_in stable until gnt[i] is seen high.
  - Operands are sampled only at the granting edge; later changes have no effect on the transaction in flight.
  - A req still high in the cycle after gnt counts as a new request. It is arbitrated again in the next IDLE cycle.
- Round-robin pointer last_gnt resets to N-1, so requester 0 has top priority after reset.
- Requests arriving during EVAL are not lost. They are sampled in the following IDLE cycle.
- nor_a and nor_b hold their last values between transactions. rsp_y holds its last value until the next capture.
- Reset values: state=IDLE, gnt=0, rsp_valid=0, rsp_y=0, nor_a=0, nor_b=0, busy=0, last_gnt=N-1.
- Reset asserted mid-transaction: everything clears immediately and asynchronously. The in-flight result is discarded and no rsp_valid pulse is produced.

## Timing
- Edge E0 samples req != 0 in IDLE. After E0: gnt[w]=1, nor_a and nor_b valid, busy=1.
- Edge E1 captures nor_y. After E1: rsp_valid[w]=1, rsp_y valid, gnt=0, busy=0.
- Request-to-result latency: 2 edges from the sampling edge.
- Throughput: one transaction per 2 cycles.
- With continuous requests, gnt pulses every other cycle. rsp_valid for transaction k coincides with the cycle in which gnt for transaction k+1 is decided, so the two pulses are never high in the same cycle.
- nor_y must settle within one clock period; the array is combinational.
- gnt and rsp_valid are always one-hot or zero, never multi-hot.

## Test plan
- Single request:
  - Stimulus: N=4, W=8, req=0001, a0=0x0F, b0=0x30.
  - Response: gnt=0001 one cycle after sampling; nor_a=0x0F, nor_b=0x30. Next cycle rsp_valid=0001, rsp_y=0xC0. busy high for exactly 1 cycle.
- All requesters held high from reset release:
  - Response: grant order 0,1,2,3,0 with gnt pulses 2 cycles apart. Each rsp_valid matches the prior grant and carries the correct NOR of that requester's operands.
- Fairness:
  - Stimulus: after a grant to requester 2, raise req=0101 during EVAL.
  - Response: next grant to 0 (search order 3,0,1,2), then to 2. Never to 2 twice in a row while requester 0 is pending.
- Operand corners:
  - a=0x00, b=0x00 -> rsp_y=0xFF.
  - a=0xFF, b=0x00 -> rsp_y=0x00.
  - a=0xAA, b=0x55 -> rsp_y=0x00.
  - a=0xA0, b=0x05 -> rsp_y=0x5A.
- Operand change after grant:
  - Stimulus: a1=0x00, b1=0x00 at the grant edge; change a1 to 0xFF in the EVAL cycle.
  - Response: rsp_y=0xFF, i.e. the operands sampled at the grant edge.
- Reset mid-EVAL:
  - Stimulus: pull rst_n low while busy=1.
  - Response: all outputs 0 immediately, and no rsp_valid pulse ever appears for that transaction. After release, req=1010 grants requester 1 first.
